// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add per clock, LSB first, WIDTH+2 cycles per operation.
// Optional overflow flag output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    s_bit    = sh_a[0] ^ sh_b[0] ^ carry;
    c_next   = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {s_bit, sum[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            state <= DONE;
            cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry holds the carry into the MSB while the MSB is being added
            ovf   <= carry ^ c_next;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  request to add; sampled only in IDLE.
REQ-005 Port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 Port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 Port cin  input  1  carry-in, captured on accepted start.
REQ-008 Port busy  output  1  high while an addition is in progress (state RUN).
REQ-009 Port done  output  1  one-cycle pulse: sum/cout valid.
REQ-010 Port sum  output  WIDTH  result, LSB-first assembled.
REQ-011 Port cout  output  1  final carry-out.

Function
REQ-012 FSM states IDLE, RUN, DONE; encoding is free.
REQ-013 IDLE: start=1 at rising edge -> load a,b into shift registers, carry register <= cin, bit counter <= 0, state -> RUN.
REQ-014 RUN: each edge computes a one-bit full add of the current LSBs of the A/B shift registers with the carry register: s = a0^b0^c, c' = a0&b0 | a0&c | b0&c.
REQ-015 RUN: s shifts into the MSB of the sum register (sum shifts right), A/B shift right, carry register <= c', counter increments.
REQ-016 RUN lasts exactly WIDTH edges; on the edge that processes bit WIDTH-1, state -> DONE and cout <= c'.
REQ-017 DONE: done=1 for exactly one cycle, state -> IDLE on the next edge unconditionally.
REQ-018 Latency: start accepted at edge k -> done high in the cycle following edge k+WIDTH.
REQ-019 sum and cout hold their last value from DONE until the next accepted start's RUN overwrites them; they do not change in IDLE.
REQ-020 start while in RUN or DONE is ignored; no queuing; a, b, cin changes during RUN have no effect.
REQ-021 start held high continuously -> back-to-back additions, one every WIDTH+2 cycles.
REQ-022 Result equals (a + b + cin) modulo 2^(WIDTH+1), split as {cout, sum}.

Reset
REQ-023 rst_n=0 asynchronously forces state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry register=0.
REQ-024 Reset asserted mid-RUN aborts the addition; no done pulse is produced for it.
REQ-025 After rst_n deasserts, the first start is accepted on the first rising edge.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN defined: extra output ovf (1 bit) is present, = carry into bit WIDTH-1 XOR final carry-out, registered with cout, reset to 0, held like cout.
REQ-027 Macro SERIAL_ADDER_OVF_EN undefined: ovf port and its logic are absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 a=0x0F, b=0x01, cin=0, start pulse -> busy 8 cycles, done pulse, sum=0x10, cout=0 (ovf=0).
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (ovf=0); a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 a=0x7F, b=0x01, cin=0 with SERIAL_ADDER_OVF_EN -> sum=0x80, cout=0, ovf=1.
REQ-031 start re-pulsed with a=0x55 at RUN cycle 3 of a 0x01+0x01 add -> ignored, sum=0x02, exactly one done.
REQ-032 rst_n pulled low at RUN cycle 4 -> busy=0, sum=0x00 immediately; no done; next start 0x03+0x04 -> sum=0x07.
REQ-033 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart, each result correct.
